s_term_pipe_tile: RTL and testbench
===================================

S_TERM_PIPE_TILE -- requirements
Module: s_term_pipe_tile

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20, number of frame strobes per column.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32, frame data width; minimum 8.
REQ-003 SHALL have parameters W1/W2/W4, defaults 4/8/16, widths of the single, double and quad wire groups.
REQ-004 SHALL have parameter PIPE_DEPTH, default 2, registered-mode stage count; legal range 1..4.
REQ-005 SHALL have parameter CFG_FRAME, default 0, index of the strobe that loads configuration.
REQ-006 Ports, in order: UserCLK in 1 tile clock; RST in 1 asynchronous active-high reset.
REQ-007 Configuration: FrameData in FrameBitsPerRow; FrameStrobe in MaxFramesPerCol; FrameData_O out FrameBitsPerRow; FrameStrobe_O out MaxFramesPerCol.
REQ-008 Wires in: S1END W1; S2MID W2; S2END W2; S4END W4.
REQ-009 Wires out: N1BEG W1; N2BEG W2; N2BEGb W2; N4BEG W4.
REQ-010 Status: GrpReady out 4, one bit per group, set when the group's output is valid.

Function
REQ-011 Groups: g0 = S1END->N1BEG; g1 = S2MID->N2BEG; g2 = S2END->N2BEGb; g3 = S4END->N4BEG; bit i maps to bit i.
REQ-012 Configuration register cfg[7:0] SHALL load FrameData[7:0] on the UserCLK rising edge when FrameStrobe[CFG_FRAME]=1; it SHALL hold otherwise.
REQ-013 cfg[2g+1:2g] SHALL select the mode of group g: 00 combinational pass; 01 registered; 10 tie 0; 11 tie 1.
REQ-014 Pass mode: output SHALL equal input with zero latency.
REQ-015 Registered mode: output SHALL equal input delayed exactly PIPE_DEPTH UserCLK cycles.
REQ-016 Each group SHALL run an FSM with states RUN and FILL, plus a fill counter of width clog2(PIPE_DEPTH+1).
REQ-017 On any cfg load that changes a group's mode to 01, that group SHALL enter FILL, clear its counter, and drive its output to 0.
REQ-018 In FILL the counter SHALL increment every cycle; on reaching PIPE_DEPTH the group SHALL go to RUN on the next edge.
REQ-019 Pipeline stages SHALL shift in every mode, so that data is valid when the group reaches RUN.
REQ-020 A cfg load that leaves a group's mode unchanged SHALL NOT disturb that group's state.
REQ-021 A cfg load into mode 00, 10 or 11 SHALL force the group to RUN immediately in the same edge.
REQ-022 A cfg load that changes mode during FILL SHALL restart or terminate FILL as per REQ-017 and REQ-021.
REQ-023 GrpReady[g] SHALL be 1 exactly when group g is in RUN.
REQ-024 FrameData_O and FrameStrobe_O SHALL be combinational copies of FrameData and FrameStrobe.

Reset
REQ-025 RST=1 SHALL asynchronously clear cfg to 0 (all groups pass), all pipeline stages to 0 and all fill counters to 0, and set all groups to RUN.
REQ-026 After reset, GrpReady SHALL be 4'b1111 and the N outputs SHALL equal the S inputs.
REQ-027 Reset asserted during FILL SHALL abort FILL; reset deassertion SHALL take effect synchronously to UserCLK.

Structure
REQ-028 A shared package SHALL hold the mode encodings (MODE_PASS, MODE_REG, MODE_TIE0, MODE_TIE1) and the FSM state type.
REQ-029 One sub-module, s_term_pipe_group, parametrised by width and PIPE_DEPTH, SHALL contain the mode mux, pipeline, FSM and counter.
REQ-030 s_term_pipe_group SHALL be instantiated four times.

Verification
REQ-031 Apply reset, drive S2END=8'hA5 -> N2BEGb=8'hA5 in the same cycle; GrpReady=4'hF.
REQ-032 Load FrameStrobe[0]=1 with FrameData[7:0]=8'h01 (g0 registered) and PIPE_DEPTH=2 -> GrpReady[0]=0 and N1BEG=0 for 2 cycles; then N1BEG follows S1END with 2-cycle delay and GrpReady[0]=1.
REQ-033 Load cfg=8'hE0 -> N4BEG=16'hFFFF and N2BEGb=8'h00 immediately after the edge; groups 0 and 1 remain pass.
REQ-034 Start FILL on g1 with cfg=8'h04, then load cfg=8'h00 one cycle later -> GrpReady[1]=1 and N2BEG=S2MID after that edge.
REQ-035 Assert RST mid-FILL -> cfg=0, GrpReady=4'hF and pass behaviour restored with no clock edge.
REQ-036 Load with FrameStrobe[CFG_FRAME]=0 and FrameData=8'hFF -> cfg unchanged; FrameData_O equals FrameData.

Source files
------------

// File: rtl/s_term_pipe_tile_pkg.sv
// Shared definitions for the south-terminating pipe tile: group mode
// encodings and the per-group fill FSM state type.
package s_term_pipe_tile_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_REG  = 2'b01,
    MODE_TIE0 = 2'b10,
    MODE_TIE1 = 2'b11
  } mode_e;

  typedef enum logic {
    RUN  = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  localparam int unsigned CFG_BITS = 8;

endpackage

// File: rtl/s_term_pipe_group.sv
// One wire group: mode mux, free-running delay pipeline, and the fill FSM that
// masks the registered output until the pipeline holds post-config data.
module s_term_pipe_group
  import s_term_pipe_tile_pkg::*;
#(
  parameter int unsigned W          = 4,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  mode_e        mode,
  input  logic         load,
  input  mode_e        mode_nxt,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         ready
);

  localparam int unsigned CW = $clog2(PIPE_DEPTH + 1);

  logic [W-1:0] pipe [PIPE_DEPTH];
  fill_state_e  state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // The pipeline shifts regardless of mode so data is already valid on RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A mode change wins over fill progress; an unchanged reload is ignored.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (load && (mode_nxt != mode)) begin
      cnt_nxt   = '0;
      state_nxt = (mode_nxt == MODE_REG) ? FILL : RUN;
    end else if (state == FILL) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == CW'(PIPE_DEPTH - 1)) state_nxt = RUN;
    end
  end

  always_comb begin
    dout = '0;
    unique case (mode)
      MODE_PASS: dout = din;
      MODE_REG:  dout = (state == RUN) ? pipe[PIPE_DEPTH-1] : '0;
      MODE_TIE0: dout = '0;
      MODE_TIE1: dout = '1;
      default:   dout = '0;
    endcase
  end

  assign ready = (state == RUN);

endmodule

// File: rtl/s_term_pipe_tile.sv
// South-terminating pipe tile: routes S wire groups to N outputs under a
// frame-loaded 8-bit configuration, two mode bits per group.
module s_term_pipe_tile
  import s_term_pipe_tile_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned W1             = 4,
  parameter int unsigned W2             = 8,
  parameter int unsigned W4             = 16,
  parameter int unsigned PIPE_DEPTH     = 2,
  parameter int unsigned CFG_FRAME      = 0
) (
  input  logic                       UserCLK,
  input  logic                       RST,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  input  logic [W1-1:0]              S1END,
  input  logic [W2-1:0]              S2MID,
  input  logic [W2-1:0]              S2END,
  input  logic [W4-1:0]              S4END,
  output logic [W1-1:0]              N1BEG,
  output logic [W2-1:0]              N2BEG,
  output logic [W2-1:0]              N2BEGb,
  output logic [W4-1:0]              N4BEG,
  output logic [3:0]                 GrpReady
);

  logic [CFG_BITS-1:0] cfg;
  logic [CFG_BITS-1:0] cfg_in;
  logic                load;

  assign load   = FrameStrobe[CFG_FRAME];
  assign cfg_in = FrameData[CFG_BITS-1:0];

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST)       cfg <= '0;
    else if (load) cfg <= cfg_in;
  end

  assign FrameData_O   = FrameData;
  assign FrameStrobe_O = FrameStrobe;

  s_term_pipe_group #(.W(W1), .PIPE_DEPTH(PIPE_DEPTH)) u_g0 (
    .clk(UserCLK), .rst(RST), .mode(mode_e'(cfg[1:0])), .load(load),
    .mode_nxt(mode_e'(cfg_in[1:0])), .din(S1END), .dout(N1BEG), .ready(GrpReady[0])
  );

  s_term_pipe_group #(.W(W2), .PIPE_DEPTH(PIPE_DEPTH)) u_g1 (
    .clk(UserCLK), .rst(RST), .mode(mode_e'(cfg[3:2])), .load(load),
    .mode_nxt(mode_e'(cfg_in[3:2])), .din(S2MID), .dout(N2BEG), .ready(GrpReady[1])
  );

  s_term_pipe_group #(.W(W2), .PIPE_DEPTH(PIPE_DEPTH)) u_g2 (
    .clk(UserCLK), .rst(RST), .mode(mode_e'(cfg[5:4])), .load(load),
    .mode_nxt(mode_e'(cfg_in[5:4])), .din(S2END), .dout(N2BEGb), .ready(GrpReady[2])
  );

  s_term_pipe_group #(.W(W4), .PIPE_DEPTH(PIPE_DEPTH)) u_g3 (
    .clk(UserCLK), .rst(RST), .mode(mode_e'(cfg[7:6])), .load(load),
    .mode_nxt(mode_e'(cfg_in[7:6])), .din(S4END), .dout(N4BEG), .ready(GrpReady[3])
  );

endmodule

// File: tb/tb_s_term_pipe_tile.sv
// Scoreboard bench for s_term_pipe_tile: stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_s_term_pipe_tile;

  logic        UserCLK = 1'b0;
  logic        RST;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic [31:0] FrameData_O;
  logic [19:0] FrameStrobe_O;
  logic [3:0]  S1END, N1BEG;
  logic [7:0]  S2MID, S2END, N2BEG, N2BEGb;
  logic [15:0] S4END, N4BEG;
  logic [3:0]  GrpReady;

  s_term_pipe_tile #(
    .MaxFramesPerCol(20), .FrameBitsPerRow(32), .W1(4), .W2(8), .W4(16),
    .PIPE_DEPTH(2), .CFG_FRAME(0)
  ) dut (
    .UserCLK(UserCLK), .RST(RST),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .FrameData_O(FrameData_O), .FrameStrobe_O(FrameStrobe_O),
    .S1END(S1END), .S2MID(S2MID), .S2END(S2END), .S4END(S4END),
    .N1BEG(N1BEG), .N2BEG(N2BEG), .N2BEGb(N2BEGb), .N4BEG(N4BEG),
    .GrpReady(GrpReady)
  );

  always #5 UserCLK = ~UserCLK;

  localparam int unsigned S_N1 = 0, S_N2 = 1, S_N2B = 2, S_N4 = 3,
                          S_RDY = 4, S_FD = 5, S_FS = 6;

  typedef struct {
    int unsigned sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic expect_v(input int unsigned sel, input logic [31:0] e, input string n);
    chk_t c;
    c.sel  = sel;
    c.exp  = e;
    c.name = n;
    sb.push_back(c);
  endtask

  function automatic logic [31:0] observe(input int unsigned sel);
    case (sel)
      S_N1:    return {28'b0, N1BEG};
      S_N2:    return {24'b0, N2BEG};
      S_N2B:   return {24'b0, N2BEGb};
      S_N4:    return {16'b0, N4BEG};
      S_RDY:   return {28'b0, GrpReady};
      S_FD:    return FrameData_O;
      S_FS:    return {12'b0, FrameStrobe_O};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  initial begin : monitor
    chk_t c;
    logic [31:0] act;
    forever begin
      @(negedge UserCLK);
      while (sb.size() != 0) begin
        c   = sb.pop_front();
        act = observe(c.sel);
        n_cmp++;
        if (act !== c.exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge UserCLK);
    #1;
  endtask

  logic [3:0] s1_vec  [6] = '{4'h3, 4'h5, 4'h9, 4'hC, 4'h6, 4'hA};
  logic [3:0] n1_exp  [6] = '{4'h3, 4'h0, 4'h0, 4'h5, 4'h9, 4'hC};
  logic [3:0] rdy_exp [6] = '{4'hF, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF};

  initial begin : stim
    RST = 1'b1; FrameData = '0; FrameStrobe = '0;
    S1END = '0; S2MID = '0; S2END = '0; S4END = '0;

    // Reset state: all groups pass, all ready
    step();
    S1END = 4'h3; S2MID = 8'h11; S2END = 8'hA5; S4END = 16'hBEEF;
    expect_v(S_RDY, 32'hF, "rst_ready");
    expect_v(S_N2B, 32'hA5, "rst_n2b_pass");
    expect_v(S_N1, 32'h3, "rst_n1_pass");
    expect_v(S_N4, 32'hBEEF, "rst_n4_pass");
    step();
    RST = 1'b0;
    expect_v(S_N2, 32'h11, "post_rst_n2_pass");
    expect_v(S_RDY, 32'hF, "post_rst_ready");
    step();

    // g0 registered: two masked cycles, then two-cycle delayed data
    for (int i = 0; i < 6; i++) begin
      step();
      FrameStrobe = (i == 0) ? 20'h1 : 20'h0;
      FrameData   = (i == 0) ? 32'h01 : 32'h0;
      S1END       = s1_vec[i];
      expect_v(S_N1, {28'b0, n1_exp[i]}, $sformatf("g0_reg_n1_%0d", i));
      expect_v(S_RDY, {28'b0, rdy_exp[i]}, $sformatf("g0_reg_rdy_%0d", i));
    end

    // cfg=E0: g2 tie0, g3 tie1, g0/g1 pass
    step();
    FrameStrobe = 20'h1; FrameData = 32'hE0;
    S1END = 4'h7; S2END = 8'h5A; S4END = 16'h1234;
    expect_v(S_N1, 32'h6, "g0_reg_before_e0");
    expect_v(S_FD, 32'hE0, "fd_copy_e0");
    expect_v(S_FS, 32'h1, "fs_copy_1");
    step();
    FrameStrobe = '0; FrameData = '0;
    expect_v(S_N4, 32'hFFFF, "e0_n4_tie1");
    expect_v(S_N2B, 32'h00, "e0_n2b_tie0");
    expect_v(S_N1, 32'h7, "e0_n1_pass");
    expect_v(S_N2, 32'h11, "e0_n2_pass");
    expect_v(S_RDY, 32'hF, "e0_ready");

    // Data without strobe must not load
    step();
    FrameData = 32'hFF;
    expect_v(S_FD, 32'hFF, "fd_copy_ff");
    expect_v(S_FS, 32'h0, "fs_copy_0");
    step();
    FrameData = '0;
    expect_v(S_N4, 32'hFFFF, "nostrobe_n4_hold");
    expect_v(S_N2B, 32'h00, "nostrobe_n2b_hold");
    expect_v(S_N1, 32'h7, "nostrobe_n1_hold");

    // FILL on g1 aborted by reload to pass one cycle later
    step();
    FrameStrobe = 20'h1; FrameData = 32'h04; S2MID = 8'h3C;
    expect_v(S_N2, 32'h3C, "g1_pass_before");
    step();
    FrameData = 32'h00;
    expect_v(S_RDY, 32'hD, "g1_fill_ready");
    expect_v(S_N2, 32'h00, "g1_fill_masked");
    expect_v(S_N4, 32'h1234, "g3_back_to_pass");
    expect_v(S_N2B, 32'h5A, "g2_back_to_pass");
    step();
    FrameStrobe = '0;
    expect_v(S_RDY, 32'hF, "g1_abort_ready");
    expect_v(S_N2, 32'h3C, "g1_abort_pass");

    // Reset mid-FILL takes effect without a clock edge
    step();
    FrameStrobe = 20'h1; FrameData = 32'h04; S2MID = 8'h66;
    step();
    FrameStrobe = '0; FrameData = '0;
    expect_v(S_RDY, 32'hD, "g1_fill2_ready");
    expect_v(S_N2, 32'h00, "g1_fill2_masked");
    step();
    RST = 1'b1;
    expect_v(S_RDY, 32'hF, "async_rst_ready");
    expect_v(S_N2, 32'h66, "async_rst_n2_pass");
    expect_v(S_N4, 32'h1234, "async_rst_n4_pass");
    expect_v(S_N2B, 32'h5A, "async_rst_n2b_pass");
    step();
    RST = 1'b0; S4END = 16'h0F0F;
    expect_v(S_RDY, 32'hF, "rst_hold_ready");
    expect_v(S_N4, 32'h0F0F, "rst_hold_n4");
    step();
    step();
    expect_v(S_N2, 32'h66, "after_rst_n2_pass");
    expect_v(S_N1, 32'h7, "after_rst_n1_pass");
    expect_v(S_RDY, 32'hF, "after_rst_ready");

    step();
    step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
